// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the VGA draw arbiter and its raster counter.
// Screen geometry is fixed by the 160x120 vga_adapter.
package draw_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOUR_W_DEF = 3;
  localparam int SZ_W_DEF     = 5;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  // Raster counters must reach 159/119 for the full-screen sweep.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vga_draw_arbiter_raster.sv
// Row-major col/row counter: step advances one pixel, start returns to origin.
// last flags the final pixel of a w x h area (immediately true when either is zero).
module rect_raster
  import draw_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [CNT_W-1:0] w,
  input  logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  logic zero_area;

  assign zero_area = (w == '0) || (h == '0);
  assign last      = zero_area ||
                     ((col == w - CNT_W'(1)) && (row == h - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col == w - CNT_W'(1)) begin
        col <= '0;
        row <= row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the vga_adapter pixel port between NUM_REQ rectangle requesters and a clear sweep.
// Grant and first pixel one cycle after req is sampled in IDLE; one pixel per clock.
module vga_draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SZ_W     = SZ_W_DEF
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       rect_x,
  input  logic [NUM_REQ*Y_W-1:0]       rect_y,
  input  logic [NUM_REQ*SZ_W-1:0]      rect_w,
  input  logic [NUM_REQ*SZ_W-1:0]      rect_h,
  input  logic [NUM_REQ*COLOUR_W-1:0]  rect_colour,
  input  logic                         clear_req,
  input  logic [COLOUR_W-1:0]          clear_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         clear_done,
  output logic                         busy,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    cur;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    cand;
  logic                pick_vld;
  logic                is_clear;
  logic                last_q;

  logic [X_W-1:0]      lat_x;
  logic [Y_W-1:0]      lat_y;
  logic [SZ_W-1:0]     lat_w;
  logic [SZ_W-1:0]     lat_h;
  logic [COLOUR_W-1:0] lat_c;

  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [CNT_W-1:0]    base_w;
  logic [CNT_W-1:0]    base_h;
  logic [COLOUR_W-1:0] base_c;

  logic [CNT_W-1:0]    col;
  logic [CNT_W-1:0]    row;
  logic                last;
  logic                step;
  logic                start;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                on_screen;

  // Round-robin: scanning downwards leaves the first set bit at or after ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // In IDLE the launching pixel is built straight from the inputs, since the
  // latch only captures them on the same edge.
  always_comb begin
    base_x = lat_x;
    base_y = lat_y;
    base_w = CNT_W'(lat_w);
    base_h = CNT_W'(lat_h);
    base_c = lat_c;
    if (state == ST_IDLE) begin
      if (clear_req) begin
        base_x = '0;
        base_y = '0;
        base_w = CNT_W'(SCR_W);
        base_h = CNT_W'(SCR_H);
        base_c = clear_colour;
      end else begin
        base_x = rect_x[pick*X_W +: X_W];
        base_y = rect_y[pick*Y_W +: Y_W];
        base_w = CNT_W'(rect_w[pick*SZ_W +: SZ_W]);
        base_h = CNT_W'(rect_h[pick*SZ_W +: SZ_W]);
        base_c = rect_colour[pick*COLOUR_W +: COLOUR_W];
      end
    end else if (state == ST_CLEAR) begin
      base_x = '0;
      base_y = '0;
      base_w = CNT_W'(SCR_W);
      base_h = CNT_W'(SCR_H);
    end
  end

  assign step  = ((state == ST_IDLE) && (clear_req || pick_vld)) ||
                 (((state == ST_DRAW) || (state == ST_CLEAR)) && !last_q);
  assign start = (state == ST_DONE);

  // One bit of headroom so off-screen pixels never alias back onto the screen.
  assign sum_x     = (X_W+1)'(base_x) + (X_W+1)'(col);
  assign sum_y     = (Y_W+1)'(base_y) + (Y_W+1)'(row);
  assign on_screen = (sum_x < (X_W+1)'(SCR_W)) && (sum_y < (Y_W+1)'(SCR_H)) &&
                     (base_w != '0) && (base_h != '0);

  rect_raster u_raster (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .start (start),
    .step  (step),
    .w     (base_w),
    .h     (base_h),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cur        <= '0;
      is_clear   <= 1'b0;
      last_q     <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_w      <= '0;
      lat_h      <= '0;
      lat_c      <= '0;
      grant      <= '0;
      done       <= '0;
      clear_done <= 1'b0;
      busy       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
    end else begin
      done       <= '0;
      clear_done <= 1'b0;
      plot       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            is_clear <= 1'b1;
            lat_c    <= clear_colour;
            busy     <= 1'b1;
          end else if (pick_vld) begin
            state    <= ST_DRAW;
            is_clear <= 1'b0;
            cur      <= pick;
            grant    <= NUM_REQ'(1) << pick;
            lat_x    <= base_x;
            lat_y    <= base_y;
            lat_w    <= rect_w[pick*SZ_W +: SZ_W];
            lat_h    <= rect_h[pick*SZ_W +: SZ_W];
            lat_c    <= base_c;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR, ST_DRAW: begin
          if (last_q) begin
            state <= ST_DONE;
            grant <= '0;
            if (is_clear) begin
              clear_done <= 1'b1;
            end else begin
              done <= NUM_REQ'(1) << cur;
              ptr  <= (int'(cur) == NUM_REQ - 1) ? '0 : cur + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          last_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Every raster step puts exactly one pixel on the port.
      if (step) begin
        x      <= sum_x[X_W-1:0];
        y      <= sum_y[Y_W-1:0];
        colour <= base_c;
        plot   <= on_screen;
        last_q <= last;
      end
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: expected pixels queued at launch, popped as plot pulses appear.
module tb_vga_draw_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 5;

  logic              CLOCK_50 = 1'b0;
  logic              resetn   = 1'b0;
  logic [N-1:0]      req      = '0;
  logic [N*XW-1:0]   rect_x   = '0;
  logic [N*YW-1:0]   rect_y   = '0;
  logic [N*SW-1:0]   rect_w   = '0;
  logic [N*SW-1:0]   rect_h   = '0;
  logic [N*CW-1:0]   rect_colour = '0;
  logic              clear_req    = 1'b0;
  logic [CW-1:0]     clear_colour = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              clear_done;
  logic              busy;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CW-1:0]     colour;
  logic              plot;

  vga_draw_arbiter dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .req          (req),
    .rect_x       (rect_x),
    .rect_y       (rect_y),
    .rect_w       (rect_w),
    .rect_h       (rect_h),
    .rect_colour  (rect_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .grant        (grant),
    .done         (done),
    .clear_done   (clear_done),
    .busy         (busy),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  typedef struct {
    logic [N-1:0] mask;
    int rx;
    int ry;
    int w;
    int h;
    int c;
    int first;
  } vec_t;

  pix_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_ptr  = 0;
  int   cyc;
  int   fx[N], fy[N], fw[N], fh[N], fc[N];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel scoreboard: every plot must match the oldest expected pixel.
  always @(negedge CLOCK_50) begin : monitor
    pix_t p;
    if (plot) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d colour=%0d, expected none", x, y, colour);
      end else begin
        p = expq.pop_front();
        check("pix_x", int'(x), p.x);
        check("pix_y", int'(y), p.y);
        check("pix_colour", int'(colour), p.c);
      end
    end
  end

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      rect_x[i*XW +: XW]      = XW'(fx[i]);
      rect_y[i*YW +: YW]      = YW'(fy[i]);
      rect_w[i*SW +: SW]      = SW'(fw[i]);
      rect_h[i*SW +: SW]      = SW'(fh[i]);
      rect_colour[i*CW +: CW] = CW'(fc[i]);
    end
  endtask

  task automatic push_rect(input int i, input int max_pix);
    int n;
    n = 0;
    for (int r = 0; r < fh[i]; r++) begin
      for (int c = 0; c < fw[i]; c++) begin
        if (n < max_pix && (fx[i] + c) < 160 && (fy[i] + r) < 120)
          expq.push_back('{fx[i] + c, fy[i] + r, fc[i]});
        n++;
      end
    end
  endtask

  // Serves every requester in mask; order comes from the bench's own pointer model.
  task automatic svc(input logic [N-1:0] mask, input int first_exp, input bit do_launch);
    int order[$];
    logic [N-1:0] pend;
    logic [N-1:0] pg;
    int p, idx, k, n, start, exp_start;
    pend = mask;
    p    = m_ptr;
    idx  = 0;
    while (pend != '0) begin
      for (int s = 0; s < N; s++) begin
        idx = (p + s) % N;
        if (pend[idx]) break;
      end
      order.push_back(idx);
      pend[idx] = 1'b0;
      p = (idx + 1) % N;
    end
    check("first_served", order[0], first_exp);
    foreach (order[j]) push_rect(order[j], 1024);
    if (do_launch) begin
      @(negedge CLOCK_50);
      drive_fields();
      req = req | mask;
    end
    cyc       = 0;
    k         = 0;
    pg        = '0;
    start     = 0;
    exp_start = 1;
    while (k < order.size() && cyc < 3000) begin
      @(negedge CLOCK_50);
      cyc++;
      if (grant != '0 && pg == '0) begin
        check("grant_vec", int'(grant), 1 << order[k]);
        check("grant_cycle", cyc, exp_start);
        start = cyc;
      end
      pg = grant;
      if (done != '0) begin
        n = fw[order[k]] * fh[order[k]];
        if (n == 0) n = 1;
        check("done_vec", int'(done), 1 << order[k]);
        check("done_cycle", cyc, start + n);
        req       = req & ~done;
        exp_start = cyc + 2;
        k++;
      end
    end
    check("services_completed", k, order.size());
    m_ptr = p;
    @(negedge CLOCK_50);
    check("busy_after", int'(busy), 0);
    check("grant_after", int'(grant), 0);
    check("queue_empty", expq.size(), 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[7];
    int   bad_grant, cd_cyc, g_cyc, d_cyc;

    tbl[0] = '{4'b0001,  76, 110, 16, 2, 7, 0};
    tbl[1] = '{4'b0110,  30,  20,  4, 3, 1, 1};
    tbl[2] = '{4'b0101,  10,  10,  3, 2, 3, 0};
    tbl[3] = '{4'b0001, 156, 118,  8, 4, 2, 0};
    tbl[4] = '{4'b1000,   5,   5,  0, 3, 6, 3};
    tbl[5] = '{4'b1111,   0,   0,  2, 2, 4, 0};
    tbl[6] = '{4'b0100, 119, 119,  1, 1, 5, 2};

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_clear_done", int'(clear_done), 0);
    check("rst_xy", int'(x) + int'(y) + int'(colour), 0);
    @(negedge CLOCK_50);
    #2 resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) begin
        fx[i] = tbl[v].rx + 20 * i;
        fy[i] = tbl[v].ry;
        fw[i] = tbl[v].w;
        fh[i] = tbl[v].h;
        fc[i] = (tbl[v].c + i) % 8;
      end
      svc(tbl[v].mask, tbl[v].first, 1'b1);
    end

    // Clear wins over a simultaneous rectangle request; dropping clear_req does not abort.
    fx[0] = 5; fy[0] = 5; fw[0] = 2; fh[0] = 2; fc[0] = 1;
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++)
        expq.push_back('{c, r, 5});
    push_rect(0, 1024);
    @(negedge CLOCK_50);
    drive_fields();
    clear_colour = 3'd5;
    clear_req    = 1'b1;
    req[0]       = 1'b1;
    cyc = 0; bad_grant = 0; cd_cyc = 0; g_cyc = 0; d_cyc = 0;
    while (d_cyc == 0 && cyc < 20000) begin
      @(negedge CLOCK_50);
      cyc++;
      if (cyc == 1) begin
        check("clear_busy", int'(busy), 1);
        clear_req = 1'b0;
      end
      if (cd_cyc == 0 && grant != '0) bad_grant++;
      if (clear_done) cd_cyc = cyc;
      if (g_cyc == 0 && grant != '0) g_cyc = cyc;
      if (done != '0) begin
        d_cyc = cyc;
        check("clear_then_done_vec", int'(done), 1);
        req = req & ~done;
      end
    end
    check("grant_during_clear", bad_grant, 0);
    check("clear_done_cycle", cd_cyc, 19201);
    check("grant_after_clear_cycle", g_cyc, 19203);
    check("done_after_clear_cycle", d_cyc, 19207);
    m_ptr = 1;
    @(negedge CLOCK_50);
    check("clear_queue_empty", expq.size(), 0);
    check("clear_busy_after", int'(busy), 0);

    // Reset in the middle of a rectangle: six pixels out, then abort with no done.
    fx[0] = 20; fy[0] = 30; fw[0] = 16; fh[0] = 2; fc[0] = 6;
    push_rect(0, 6);
    @(negedge CLOCK_50);
    drive_fields();
    req[0] = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    check("pre_reset_grant", int'(grant), 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_plot", int'(plot), 0);
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_xy", int'(x) + int'(y) + int'(colour), 0);
    check("mid_rst_done", int'(done), 0);
    repeat (3) begin
      @(negedge CLOCK_50);
      check("rst_hold_done", int'(done), 0);
    end
    check("rst_partial_pixels", expq.size(), 0);
    // req[3] joins req[0]; a pointer left at 1 would serve 3 first.
    fx[3] = 100; fy[3] = 50; fw[3] = 2; fh[3] = 2; fc[3] = 4;
    drive_fields();
    req[3] = 1'b1;
    m_ptr  = 0;
    #2 resetn = 1'b1;
    svc(4'b1001, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Owns the single pixel-write port (x, y, colour, plot) of the 160x120 vga_adapter.
- Shares that port between NUM_REQ sprite-draw requesters (paddle, ball, blocks, erase passes) and one full-screen clear requester.
- Each grant rasterises one axis-aligned rectangle at one pixel per clock.
- Replaces ad-hoc per-state pixel loops in the game FSM with a req/grant/done service.

Parameters:
- NUM_REQ, 4, number of rectangle requesters.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width (RGB, 1 bit per channel).
- SZ_W, 5, rectangle width/height field width (0..31).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester draw request, level.
- rect_x  in  NUM_REQ*X_W  top-left x, requester i at slice [i*X_W +: X_W].
- rect_y  in  NUM_REQ*Y_W  top-left y, same slicing.
- rect_w  in  NUM_REQ*SZ_W  width in pixels.
- rect_h  in  NUM_REQ*SZ_W  height in pixels.
- rect_colour  in  NUM_REQ*COLOUR_W  fill colour.
- clear_req  in  1  full-screen clear request, level.
- clear_colour  in  COLOUR_W  clear fill colour.
- grant  out  NUM_REQ  one-hot; high for the whole service of requester i.
- done  out  NUM_REQ  one-cycle pulse to requester i when its rectangle is finished.
- clear_done  out  1  one-cycle pulse when the clear sweep is finished.
- busy  out  1  high in every state except IDLE.
- x  out  X_W  pixel x to vga_adapter.
- y  out  Y_W  pixel y to vga_adapter.
- colour  out  COLOUR_W  pixel colour to vga_adapter.
- plot  out  1  pixel write enable to vga_adapter.

Behaviour:
- Reset: the asynchronous reset (active-low, as decided) forces state IDLE, all outputs 0, round-robin pointer 0, and all internal counters 0. Reset mid-draw aborts the service; no done is pulsed.
- States: IDLE, CLEAR, DRAW, DONE. All outputs are registered.
- IDLE, priority order:
  - clear_req=1 -> CLEAR.
  - Otherwise any req bit set -> pick the first set bit at or after pointer (modulo NUM_REQ) -> DRAW.
  - On entry to DRAW, latch that requester's rect fields and colour, and set grant[i].
  - Simultaneous clear_req and req: the clear is served first; req stays pending.
- Latency: req sampled high in IDLE at edge t -> grant[i]=1 and the first pixel (plot=1) at t+1.
- DRAW:
  - Pixel k of the rectangle is driven at cycle t+1+k, row-major: col 0..w-1 is the inner loop, row 0..h-1 the outer loop.
  - x = rx+col, y = ry+row.
  - On the last pixel (col=w-1, row=h-1) -> DONE.
- Zero size: w=0 or h=0 -> DRAW lasts 1 cycle with plot=0 and grant[i]=1, then DONE.
- Clipping:
  - Sums are computed at X_W+1 / Y_W+1 bits.
  - A pixel with sum x>=160 or y>=120 is counted but has plot=0; no wrap-around onto the screen.
- DONE:
  - grant=0, plot=0, done[i]=1 for exactly one cycle.
  - Pointer <= i+1 mod NUM_REQ.
  - Next state IDLE.
- Requester rules:
  - Hold req and rect fields stable from assertion until grant.
  - Fields are not re-sampled after grant.
  - Drop req in the cycle done is seen. A req still high when the arbiter is back in IDLE is treated as a new request.
- CLEAR:
  - Sweeps x 0..159 (inner) and y 0..119 (outer) with clear_colour and plot=1: 19200 cycles.
  - Then one cycle with clear_done=1 -> IDLE.
  - clear_req falling mid-sweep does not abort the sweep.
- Throughput: minimum gap between back-to-back services is 2 cycles (DONE + IDLE).
- Outputs outside DRAW/CLEAR: plot=0; x/y/colour hold their last value.

Decomposition:
- Package draw_arb_pkg:
  - State enum.
  - SCR_W=160, SCR_H=120.
  - Parameter defaults.
- Sub-module rect_raster:
  - Inputs: start, w, h.
  - Outputs: col, row, last.
  - Row-major counter reused by both DRAW (w,h from the latch) and CLEAR (w=160, h=120).
  - Needs count widths of 8 bits to cover the 160/120 sweep.

Test Plan:
- Single request: req[0] with (76,110,16,2,3'b111) -> grant[0] at t+1; 32 plots covering x 76..91, y 110..111; done[0] pulse at t+33; busy low at t+34.
- Contention: req[1] and req[2] both high in IDLE with pointer=0 -> requester 1 served first, then 2. After that, req[0] and req[2] -> 0 before 2 (pointer=3, so the next set bit at or after 3 mod 4 is 0).
- Clear priority: clear_req and req[0] rise in the same cycle -> 19200 plots of clear_colour, clear_done pulse, then grant[0]; no rect pixels during the clear.
- Clipping: rect (156,118,8,4,3'b010) -> 32 service cycles; plot=1 only for x 156..159 with y 118..119 (8 pixels); done[0] at t+33.
- Zero size: rect_w=0 on req[3] -> grant[3] for 1 cycle with plot=0, then done[3] pulse; no pixels written.
- Reset mid-draw: deassert resetn at pixel 5 of a 16x2 rect -> outputs 0 immediately, no done; after release the arbiter is in IDLE with pointer 0, and a held req[0] is re-served from pixel 0.
